// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection, flush and external stall
// Optional performance counters are built only when ID_EX_PERF_CNT_EN is defined.

module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [1:0]  imm_sel_d,
    input  logic [1:0]  alu_type_sel_d,
    input  logic        b_imm_sel_d,
    input  logic        branch_d,
    input  logic        jump_d,
    input  logic        memwrite_en_d,
    input  logic        regwrite_en_d,
    input  logic        wb_sel_d,
    input  logic [2:0]  alucontrol_d,
    input  logic [6:0]  alucontrol7_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] pc_plus4_d,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic [31:0] imm_d,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rd_d,
    input  logic        valid_d,

    input  logic        flush_e,
    input  logic        stall_ext,

    output logic [1:0]  imm_sel_e,
    output logic [1:0]  alu_type_sel_e,
    output logic        b_imm_sel_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic        memwrite_en_e,
    output logic        regwrite_en_e,
    output logic        wb_sel_e,
    output logic [2:0]  alucontrol_e,
    output logic [6:0]  alucontrol7_e,
    output logic [31:0] pc_e,
    output logic [31:0] pc_plus4_e,
    output logic [31:0] rd1_e,
    output logic [31:0] rd2_e,
    output logic [31:0] imm_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output logic        valid_e,

    output logic        stall_f,
    output logic        stall_d,
    output logic        bubble_e,

    output logic [31:0] bubble_cnt,
    output logic [31:0] flush_cnt
);

    logic load_use;
    logic take_bubble;
    logic load_zero;

    // A load in EX (memory writeback, not a store) whose destination is read by the ID instruction.
    assign load_use = valid_e & regwrite_en_e & wb_sel_e & ~memwrite_en_e
                    & (rd_e != 5'd0) & valid_d
                    & ((rs1_d == rd_e) | (rs2_d == rd_e));

    assign stall_f = load_use | stall_ext;
    assign stall_d = load_use | stall_ext;

    assign take_bubble = ~flush_e & ~stall_ext & load_use;
    assign load_zero   = flush_e | take_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_sel_e      <= 2'd0;
            alu_type_sel_e <= 2'd0;
            b_imm_sel_e    <= 1'b0;
            branch_e       <= 1'b0;
            jump_e         <= 1'b0;
            memwrite_en_e  <= 1'b0;
            regwrite_en_e  <= 1'b0;
            wb_sel_e       <= 1'b0;
            alucontrol_e   <= 3'd0;
            alucontrol7_e  <= 7'd0;
            pc_e           <= 32'd0;
            pc_plus4_e     <= 32'd0;
            rd1_e          <= 32'd0;
            rd2_e          <= 32'd0;
            imm_e          <= 32'd0;
            rs1_e          <= 5'd0;
            rs2_e          <= 5'd0;
            rd_e           <= 5'd0;
            valid_e        <= 1'b0;
            bubble_e       <= 1'b0;
        end else if (load_zero) begin
            imm_sel_e      <= 2'd0;
            alu_type_sel_e <= 2'd0;
            b_imm_sel_e    <= 1'b0;
            branch_e       <= 1'b0;
            jump_e         <= 1'b0;
            memwrite_en_e  <= 1'b0;
            regwrite_en_e  <= 1'b0;
            wb_sel_e       <= 1'b0;
            alucontrol_e   <= 3'd0;
            alucontrol7_e  <= 7'd0;
            pc_e           <= 32'd0;
            pc_plus4_e     <= 32'd0;
            rd1_e          <= 32'd0;
            rd2_e          <= 32'd0;
            imm_e          <= 32'd0;
            rs1_e          <= 5'd0;
            rs2_e          <= 5'd0;
            rd_e           <= 5'd0;
            valid_e        <= 1'b0;
            // Flush wins over a coincident load-use, and a flush bubble is not flagged.
            bubble_e       <= ~flush_e;
        end else if (!stall_ext) begin
            imm_sel_e      <= imm_sel_d;
            alu_type_sel_e <= alu_type_sel_d;
            b_imm_sel_e    <= b_imm_sel_d;
            // Side-effecting controls of a non-instruction must never reach EX.
            branch_e       <= branch_d & valid_d;
            jump_e         <= jump_d & valid_d;
            memwrite_en_e  <= memwrite_en_d & valid_d;
            regwrite_en_e  <= regwrite_en_d & valid_d;
            wb_sel_e       <= wb_sel_d;
            alucontrol_e   <= alucontrol_d;
            alucontrol7_e  <= alucontrol7_d;
            pc_e           <= pc_d;
            pc_plus4_e     <= pc_plus4_d;
            rd1_e          <= rd1_d;
            rd2_e          <= rd2_d;
            imm_e          <= imm_d;
            rs1_e          <= rs1_d;
            rs2_e          <= rs2_d;
            rd_e           <= rd_d;
            valid_e        <= valid_d;
            bubble_e       <= 1'b0;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    // take_bubble already excludes stall_ext, so both counters hold under stall unless flushing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 32'd0;
            flush_cnt_q  <= 32'd0;
        end else begin
            if (take_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (flush_e && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign bubble_cnt = 32'h0;
    assign flush_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a behavioural pipeline model
module tb_id_ex_stage;

    typedef struct packed {
        logic [1:0]  imm_sel;
        logic [1:0]  alu_type_sel;
        logic        b_imm_sel;
        logic        branch;
        logic        jump;
        logic        memwrite_en;
        logic        regwrite_en;
        logic        wb_sel;
        logic [2:0]  alucontrol;
        logic [6:0]  alucontrol7;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
    } ex_t;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic flush_e, stall_ext;
    ex_t  din;
    ex_t  dout;

    logic [1:0]  imm_sel_e, alu_type_sel_e;
    logic        b_imm_sel_e, branch_e, jump_e, memwrite_en_e, regwrite_en_e, wb_sel_e;
    logic [2:0]  alucontrol_e;
    logic [6:0]  alucontrol7_e;
    logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        valid_e, stall_f, stall_d, bubble_e;
    logic [31:0] bubble_cnt, flush_cnt;

    ex_t         m_e;
    logic        m_bubble;
    logic [31:0] m_bcnt, m_fcnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign dout = {imm_sel_e, alu_type_sel_e, b_imm_sel_e, branch_e, jump_e, memwrite_en_e,
                   regwrite_en_e, wb_sel_e, alucontrol_e, alucontrol7_e, pc_e, pc_plus4_e,
                   rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e, valid_e};

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imm_sel_d(din.imm_sel), .alu_type_sel_d(din.alu_type_sel), .b_imm_sel_d(din.b_imm_sel),
        .branch_d(din.branch), .jump_d(din.jump), .memwrite_en_d(din.memwrite_en),
        .regwrite_en_d(din.regwrite_en), .wb_sel_d(din.wb_sel), .alucontrol_d(din.alucontrol),
        .alucontrol7_d(din.alucontrol7), .pc_d(din.pc), .pc_plus4_d(din.pc_plus4),
        .rd1_d(din.rd1), .rd2_d(din.rd2), .imm_d(din.imm), .rs1_d(din.rs1), .rs2_d(din.rs2),
        .rd_d(din.rd), .valid_d(din.valid),
        .flush_e(flush_e), .stall_ext(stall_ext),
        .imm_sel_e(imm_sel_e), .alu_type_sel_e(alu_type_sel_e), .b_imm_sel_e(b_imm_sel_e),
        .branch_e(branch_e), .jump_e(jump_e), .memwrite_en_e(memwrite_en_e),
        .regwrite_en_e(regwrite_en_e), .wb_sel_e(wb_sel_e), .alucontrol_e(alucontrol_e),
        .alucontrol7_e(alucontrol7_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .valid_e(valid_e),
        .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    function automatic ex_t rand_d();
        ex_t d;
        d = ex_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        d.rs1   = 5'($urandom_range(0, 7));
        d.rs2   = 5'($urandom_range(0, 7));
        d.rd    = 5'($urandom_range(0, 7));
        d.valid = ($urandom_range(0, 3) != 0);
        return d;
    endfunction

    // Hazard rule evaluated on the model's view of EX and the current ID instruction.
    function automatic logic model_load_use();
        return m_e.valid && m_e.regwrite_en && m_e.wb_sel && !m_e.memwrite_en && (m_e.rd != 0)
            && din.valid && ((din.rs1 == m_e.rd) || (din.rs2 == m_e.rd));
    endfunction

    task automatic model_reset();
        m_e = '0; m_bubble = 1'b0; m_bcnt = 32'd0; m_fcnt = 32'd0;
    endtask

    task automatic tick();
        logic lu;
        lu = model_load_use();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (flush_e) begin
            m_e = '0; m_bubble = 1'b0;
            if (PERF && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        end else if (stall_ext) begin
            // pipeline frozen
        end else if (lu) begin
            m_e = '0; m_bubble = 1'b1;
            if (PERF && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
        end else begin
            m_e = din;
            if (!din.valid) begin
                m_e.regwrite_en = 1'b0; m_e.memwrite_en = 1'b0;
                m_e.branch = 1'b0; m_e.jump = 1'b0;
            end
            m_bubble = 1'b0;
        end
        #1;
    endtask

    function automatic ex_t load_x(input logic [4:0] rd);
        ex_t d;
        d = rand_d();
        d.rd = rd; d.wb_sel = 1'b1; d.regwrite_en = 1'b1; d.memwrite_en = 1'b0; d.valid = 1'b1;
        d.rs1 = 5'd0; d.rs2 = 5'd0;
        return d;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; din = rand_d(); flush_e = 1'b0; stall_ext = 1'b0;
        model_reset();
        #2;
        checks++;
        if (dout !== ex_t'(0) || bubble_e !== 1'b0) begin
            fails++; $display("FAIL reset_outputs: got %h bubble %b, want all zero", dout, bubble_e);
        end
        tick();
        checks++;
        if (dout !== ex_t'(0) || bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++; $display("FAIL reset_hold: got %h cnt %h/%h, want zero", dout, bubble_cnt, flush_cnt);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        flush_e = 1'b0; stall_ext = 1'b0;
        din = load_x(5'd5);
        tick();
        din = rand_d(); din.rs1 = 5'd5; din.rs2 = 5'd1; din.valid = 1'b1; din.pc = 32'h104;
        #1;
        checks++;
        if (stall_f !== 1'b1 || stall_d !== 1'b1) begin
            fails++; $display("FAIL lu_stall: got f=%b d=%b, want 1/1", stall_f, stall_d);
        end
        tick();
        checks++;
        if (valid_e !== 1'b0 || bubble_e !== 1'b1 || dout !== m_e || bubble_cnt !== m_bcnt) begin
            fails++; $display("FAIL lu_bubble: got %h bubble %b cnt %0d, want %h bubble 1 cnt %0d",
                              dout, bubble_e, bubble_cnt, m_e, m_bcnt);
        end
        checks++;
        if (stall_f !== 1'b0) begin
            fails++; $display("FAIL lu_one_cycle: got stall_f %b, want 0", stall_f);
        end
        tick();
        checks++;
        if (pc_e !== 32'h104 || dout !== m_e || bubble_e !== 1'b0) begin
            fails++; $display("FAIL lu_capture: got %h bubble %b, want pc 104 %h bubble 0", dout, bubble_e, m_e);
        end
    endtask

    task automatic test_no_hazard();
        flush_e = 1'b0; stall_ext = 1'b0;
        for (int k = 0; k < 2; k++) begin
            din = load_x(k == 0 ? 5'd0 : 5'd5);
            tick();
            din = rand_d(); din.valid = 1'b1;
            din.rs1 = (k == 0) ? 5'd0 : 5'd6;
            din.rs2 = (k == 0) ? 5'd0 : 5'd6;
            #1;
            checks++;
            if (stall_f !== 1'b0 || stall_d !== 1'b0) begin
                fails++; $display("FAIL no_hazard_%0d: got stall %b/%b, want 0/0", k, stall_f, stall_d);
            end
            tick();
            checks++;
            if (dout !== m_e || bubble_e !== 1'b0) begin
                fails++; $display("FAIL no_hazard_capture_%0d: got %h, want %h", k, dout, m_e);
            end
        end
    endtask

    task automatic test_flush_priority();
        logic [31:0] b0, f0;
        flush_e = 1'b0; stall_ext = 1'b0;
        din = load_x(5'd5);
        tick();
        b0 = m_bcnt; f0 = m_fcnt;
        din = rand_d(); din.valid = 1'b1; din.rs1 = 5'd5;
        flush_e = 1'b1; stall_ext = 1'b1;
        #1;
        checks++;
        if (stall_f !== 1'b1 || stall_d !== 1'b1) begin
            fails++; $display("FAIL flush_stall_out: got %b/%b, want 1/1", stall_f, stall_d);
        end
        tick();
        checks++;
        if (dout !== ex_t'(0) || bubble_e !== 1'b0 || bubble_cnt !== b0
            || flush_cnt !== (PERF ? f0 + 32'd1 : 32'd0)) begin
            fails++; $display("FAIL flush_priority: got %h bubble %b cnt %0d/%0d, want 0 bubble 0 cnt %0d/%0d",
                              dout, bubble_e, bubble_cnt, flush_cnt, b0, PERF ? f0 + 1 : 0);
        end
        flush_e = 1'b0; stall_ext = 1'b0;
    endtask

    task automatic test_stall_ext();
        ex_t held;
        logic [31:0] b0, f0;
        flush_e = 1'b0; stall_ext = 1'b0;
        din = rand_d(); din.valid = 1'b1; din.pc = 32'h0000_0200;
        tick();
        held = m_e; b0 = m_bcnt; f0 = m_fcnt;
        stall_ext = 1'b1;
        for (int c = 0; c < 3; c++) begin
            din = rand_d(); din.pc = 32'h0000_0300 + 32'(c * 4);
            #1;
            checks++;
            if (stall_f !== 1'b1 || stall_d !== 1'b1) begin
                fails++; $display("FAIL stall_ext_out_%0d: got %b/%b, want 1/1", c, stall_f, stall_d);
            end
            tick();
            checks++;
            if (dout !== held || pc_e !== 32'h0000_0200 || bubble_cnt !== b0 || flush_cnt !== f0) begin
                fails++; $display("FAIL stall_ext_hold_%0d: got %h, want %h", c, dout, held);
            end
        end
        stall_ext = 1'b0;
    endtask

    task automatic test_async_reset();
        flush_e = 1'b0; stall_ext = 1'b0;
        din = rand_d(); din.valid = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== ex_t'(0) || bubble_e !== 1'b0 || bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++; $display("FAIL async_reset: got %h bubble %b, want zero before edge", dout, bubble_e);
        end
        tick();
        #1 rst_n = 1'b1;
        din = rand_d(); din.valid = 1'b1; din.pc = 32'h0000_0004;
        tick();
        checks++;
        if (pc_e !== 32'h0000_0004 || valid_e !== 1'b1 || dout !== m_e) begin
            fails++; $display("FAIL reset_resume: got %h, want pc 4 valid 1 %h", dout, m_e);
        end
    endtask

    task automatic test_counter_saturate();
`ifdef ID_EX_PERF_CNT_EN
        flush_e = 1'b0; stall_ext = 1'b0;
        din = load_x(5'd3);
        tick();
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.bubble_cnt_q;
        m_bcnt = 32'hFFFF_FFFF;
        din = rand_d(); din.valid = 1'b1; din.rs2 = 5'd3;
        tick();
        checks++;
        if (bubble_cnt !== 32'hFFFF_FFFF || bubble_e !== 1'b1) begin
            fails++; $display("FAIL bubble_cnt_saturate: got %h bubble %b, want ffffffff bubble 1", bubble_cnt, bubble_e);
        end
`else
        checks++;
        if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++; $display("FAIL counters_tied: got %h/%h, want 0/0", bubble_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            din = rand_d();
            flush_e   = ($urandom_range(0, 7) == 0);
            stall_ext = ($urandom_range(0, 5) == 0);
            #1;
            checks++;
            if (stall_f !== (model_load_use() | stall_ext) || stall_d !== stall_f) begin
                fails++; $display("FAIL rand_stall_%0d: got %b/%b, want %b", n, stall_f, stall_d,
                                  model_load_use() | stall_ext);
            end
            tick();
            checks++;
            if (dout !== m_e || bubble_e !== m_bubble || bubble_cnt !== m_bcnt || flush_cnt !== m_fcnt) begin
                fails++; $display("FAIL rand_state_%0d: got %h b%b %0d/%0d, want %h b%b %0d/%0d", n,
                                  dout, bubble_e, bubble_cnt, flush_cnt, m_e, m_bubble, m_bcnt, m_fcnt);
            end
        end
        flush_e = 1'b0; stall_ext = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_priority();
        test_stall_ext();
        test_async_reset();
        test_counter_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
